// File: rtl/seq_frame_controller_if.sv
// Handshake and serial bus between host, frame controller and recognizer.
// Latency: n/a (signal bundle only).
// Backpressure: none; start is only honoured while the controller is idle.
// Ports (master = host/recognizer side, slave = controller):
//   start, frame, rec_z                          : into the controller
//   busy, done, hit_count, first_hit, any_hit,
//   rec_reset_n, rec_x                           : out of the controller
interface seq_frame_controller_if #(
    parameter int WIDTH = 8,
    parameter int POS_W = 4
);
    logic             start;
    logic [WIDTH-1:0] frame;
    logic             busy;
    logic             done;
    logic [POS_W-1:0] hit_count;
    logic [POS_W-1:0] first_hit;
    logic             any_hit;
    logic             rec_reset_n;
    logic             rec_x;
    logic             rec_z;

    modport master (
        output start, frame, rec_z,
        input  busy, done, hit_count, first_hit, any_hit, rec_reset_n, rec_x
    );

    modport slave (
        input  start, frame, rec_z,
        output busy, done, hit_count, first_hit, any_hit, rec_reset_n, rec_x
    );
endinterface

// File: rtl/seq_frame_controller.sv
// Clears a serial recognizer, shifts a frame into it MSB-first and tallies its hits.
// Latency: done pulses CLR_CYCLES+WIDTH edges after the edge that accepts start.
// Backpressure: start is sampled only in IDLE; requests while busy or done are dropped.
// Ports: clock, reset (async, active-high); bus (slave modport) carries
//   start/frame in, busy/done/hit_count/first_hit/any_hit out, rec_reset_n/rec_x/rec_z.
module seq_frame_controller #(
    parameter int WIDTH      = 8,
    parameter int POS_W      = 4,
    parameter int CLR_CYCLES = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    seq_frame_controller_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SHIFT, S_DONE} state_t;

    localparam int               CLR_W    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [POS_W-1:0] LAST_IDX = POS_W'(WIDTH - 1);
    localparam logic [CLR_W-1:0] LAST_CLR = CLR_W'(CLR_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [POS_W-1:0] r_idx;
    logic [POS_W-1:0] r_hit_count;
    logic [POS_W-1:0] r_first_hit;
    logic             r_any_hit;
    logic             r_rec_reset_n;
    logic             r_rec_x;
    logic [CLR_W-1:0] r_clr_cnt;
    logic             w_clr_last;
    logic             w_shift_last;

    assign w_clr_last   = (r_clr_cnt == LAST_CLR);
    assign w_shift_last = (r_idx == LAST_IDX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_CLEAR;
            S_CLEAR: if (w_clr_last) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_shift_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shift       <= '0;
            r_idx         <= '0;
            r_hit_count   <= '0;
            r_first_hit   <= '0;
            r_any_hit     <= 1'b0;
            r_rec_reset_n <= 1'b0;
            r_rec_x       <= 1'b0;
            r_clr_cnt     <= '0;
        end else begin
            // Recognizer is held in reset exactly while the next state is CLEAR,
            // so the low pulse lines up with the CLEAR cycles.
            r_rec_reset_n <= (w_state_nxt != S_CLEAR);
            case (r_state)
                S_IDLE: begin
                    r_rec_x <= 1'b0;
                    if (bus.start) begin
                        r_shift     <= bus.frame;
                        r_idx       <= '0;
                        r_hit_count <= '0;
                        r_first_hit <= '0;
                        r_any_hit   <= 1'b0;
                        r_clr_cnt   <= '0;
                    end
                end
                S_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    // Present the MSB on the same edge that releases the recognizer.
                    if (w_clr_last) r_rec_x <= r_shift[WIDTH-1];
                end
                S_SHIFT: begin
                    // rec_z reflects the bit currently on rec_x, i.e. index r_idx.
                    if (bus.rec_z) begin
                        r_hit_count <= r_hit_count + 1'b1;
                        if (!r_any_hit) begin
                            r_first_hit <= r_idx;
                            r_any_hit   <= 1'b1;
                        end
                    end
                    r_shift <= r_shift << 1;
                    r_idx   <= r_idx + 1'b1;
                    r_rec_x <= w_shift_last ? 1'b0 : r_shift[WIDTH-2];
                end
                S_DONE: begin
                    r_rec_x <= 1'b0;
                end
                default: begin
                    r_rec_x <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = (r_state == S_CLEAR) || (r_state == S_SHIFT);
    assign bus.done        = (r_state == S_DONE);
    assign bus.hit_count   = r_hit_count;
    assign bus.first_hit   = r_first_hit;
    assign bus.any_hit     = r_any_hit;
    assign bus.rec_reset_n = r_rec_reset_n;
    assign bus.rec_x       = r_rec_x;
endmodule

// File: doc/seq_frame_controller.md
Name: seq_frame_controller

Overview:
- Sequencing controller for a single-bit serial sequence recognizer (Mealy output z, active-low async reset).
- Accepts a parallel frame, clears the recognizer, then shifts the frame into the recognizer MSB-first, one bit per clock.
- Samples the recognizer's z each bit cycle and reports the hit count and first-hit position, with a start/busy/done handshake.
- Sits between the lab's host-side pattern source and the recognizer instance.

Parameters:
- WIDTH, 8, frame length in bits (>= 2).
- POS_W, 4, width of the count/position outputs; must satisfy 2^POS_W > WIDTH.
- CLR_CYCLES, 1, number of cycles the recognizer reset is held low before shifting (>= 1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request to process frame; sampled only in IDLE.
- frame  in  WIDTH  frame to send; bit WIDTH-1 is sent first.
- busy  out  1  high while in CLEAR or SHIFT.
- done  out  1  one-cycle pulse when results are valid.
- hit_count  out  POS_W  number of bit cycles in which rec_z was 1.
- first_hit  out  POS_W  bit index (0 = first bit sent) of the first hit; 0 if none.
- any_hit  out  1  at least one hit in the last frame.
- rec_reset_n  out  1  registered active-low reset to the recognizer.
- rec_x  out  1  registered serial data to the recognizer.
- rec_z  in  1  recognizer Mealy output (combinational in rec_x).

Behaviour:
- Reset (async, while reset=1): state=IDLE; busy=0, done=0, hit_count=0, first_hit=0, any_hit=0, rec_x=0, rec_reset_n=0 (recognizer held in reset). rec_reset_n rises to 1 on the first clock edge after reset deasserts.
- FSM states: IDLE, CLEAR, SHIFT, DONE. All outputs are registered or decoded from registered state only; no combinational path from start or rec_z to any output.
- IDLE:
  - rec_reset_n=1, rec_x=0.
  - On start=1: latch frame into the shift register; clear hit_count, first_hit, any_hit, and the bit index; go to CLEAR.
  - While start=0, prior results are held.
- CLEAR:
  - rec_reset_n=0 for exactly CLR_CYCLES cycles; rec_x=0.
  - Then go to SHIFT with index=0 and rec_x = frame[WIDTH-1].
- SHIFT:
  - One bit per cycle; rec_x holds bit WIDTH-1-index; rec_reset_n=1.
  - At each edge, if rec_z=1: hit_count++; if any_hit=0, set first_hit=index and any_hit=1.
  - Then shift left and increment index.
  - After the cycle with index=WIDTH-1, go to DONE with rec_x=0.
- DONE: done=1, busy=0 for exactly one cycle, then IDLE. Results are stable from DONE until the next accepted start.
- Latency: done is high in the cycle beginning CLR_CYCLES+WIDTH edges after the edge that accepted start (default 9). busy is high for CLR_CYCLES+WIDTH cycles.
- Width rules:
  - hit_count never exceeds WIDTH, so no wrap occurs.
  - first_hit ranges 0..WIDTH-1; first_hit=0 with any_hit=0 means no hit.
- Boundary conditions:
  - start while busy or in DONE is ignored (not queued).
  - Changes to frame after acceptance have no effect.
  - start held high continuously gives back-to-back frames, each with its own CLEAR, and a one-cycle IDLE gap after DONE.
  - rec_z is ignored outside SHIFT, including when rec_z=1 during CLEAR.
  - A hit on the last bit (index WIDTH-1) is counted before DONE.
  - Reset asserted mid-SHIFT returns to IDLE immediately, clears results, and pulls rec_reset_n low; no done pulse occurs for the aborted frame.

Test Plan:
1. Reset then idle: reset pulse, start=0 for 5 cycles -> busy=0, done=0, hit_count=0, any_hit=0; rec_reset_n=0 during reset and 1 after the first post-reset edge.
2. Basic frame: frame=8'hA5, start for 1 cycle, rec_z=0 -> rec_reset_n low 1 cycle; rec_x sequence 1,0,1,0,0,1,0,1; done pulses 9 cycles after acceptance; hit_count=0, any_hit=0.
3. Hits: frame=8'h50, bench drives rec_z=1 on bit indices 2 and 4 -> hit_count=2, first_hit=2, any_hit=1 at done; values held through 10 idle cycles.
4. Edge hits: rec_z=1 only at index 7, and separately at every index -> first result hit_count=1, first_hit=7; second result hit_count=8, first_hit=0; rec_z=1 during CLEAR is not counted.
5. Handshake: start pulsed at bit index 3 of a frame, and start held high for 3 frames -> the mid-frame start is ignored; the held start gives 3 done pulses, each frame separated by IDLE plus CLEAR with rec_reset_n low.
6. Abort: reset asserted at bit index 4 -> immediate IDLE, rec_reset_n=0, no done pulse; a next frame 8'hFF with rec_z=0 completes normally with hit_count=0.
